// File: rtl/mycpu_pkg.sv
// Shared pipeline definitions for the five-stage in-order core.
// Holds the ID->EX and EX->MEM bus widths, the bit positions of every field
// on both buses, and the one-hot ALU operation indices used by decode and alu.
// No ports; imported by the EX stage, its interface and the ALU.
package mycpu_pkg;

  localparam int unsigned DS_TO_ES_W = 150;
  localparam int unsigned ES_TO_MS_W = 71;

  // ID->EX bus, MSB to LSB:
  // {alu_op, pc, rj_value, rkd_value, imm, src1_is_pc, src2_is_imm,
  //  res_from_mem, mem_we, gr_we, dest}
  localparam int unsigned DS_ALU_OP_MSB     = 149;
  localparam int unsigned DS_ALU_OP_LSB     = 138;
  localparam int unsigned DS_PC_MSB         = 137;
  localparam int unsigned DS_PC_LSB         = 106;
  localparam int unsigned DS_RJ_MSB         = 105;
  localparam int unsigned DS_RJ_LSB         = 74;
  localparam int unsigned DS_RKD_MSB        = 73;
  localparam int unsigned DS_RKD_LSB        = 42;
  localparam int unsigned DS_IMM_MSB        = 41;
  localparam int unsigned DS_IMM_LSB        = 10;
  localparam int unsigned DS_SRC1_IS_PC     = 9;
  localparam int unsigned DS_SRC2_IS_IMM    = 8;
  localparam int unsigned DS_RES_FROM_MEM   = 7;
  localparam int unsigned DS_MEM_WE         = 6;
  localparam int unsigned DS_GR_WE          = 5;
  localparam int unsigned DS_DEST_MSB       = 4;
  localparam int unsigned DS_DEST_LSB       = 0;

  // EX->MEM bus, MSB to LSB: {pc, alu_result, res_from_mem, gr_we, dest}
  localparam int unsigned ES_PC_MSB         = 70;
  localparam int unsigned ES_PC_LSB         = 39;
  localparam int unsigned ES_RESULT_MSB     = 38;
  localparam int unsigned ES_RESULT_LSB     = 7;
  localparam int unsigned ES_RES_FROM_MEM   = 6;
  localparam int unsigned ES_GR_WE          = 5;
  localparam int unsigned ES_DEST_MSB       = 4;
  localparam int unsigned ES_DEST_LSB       = 0;

  // One-hot ALU operation bit indices
  localparam int unsigned ALU_OP_W    = 12;
  localparam int unsigned ALU_OP_ADD  = 0;
  localparam int unsigned ALU_OP_SUB  = 1;
  localparam int unsigned ALU_OP_SLT  = 2;
  localparam int unsigned ALU_OP_SLTU = 3;
  localparam int unsigned ALU_OP_AND  = 4;
  localparam int unsigned ALU_OP_NOR  = 5;
  localparam int unsigned ALU_OP_OR   = 6;
  localparam int unsigned ALU_OP_XOR  = 7;
  localparam int unsigned ALU_OP_SLL  = 8;
  localparam int unsigned ALU_OP_SRL  = 9;
  localparam int unsigned ALU_OP_SRA  = 10;
  localparam int unsigned ALU_OP_LUI  = 11;

endpackage

// File: rtl/exe_stage_if.sv
// Handshake and bus bundle around the execute stage.
// Carries the ID->EX valid/allowin/bus, the EX->MEM valid/allowin/bus and the
// data-SRAM request. With EXE_FWD_EN defined it also carries the EX bypass
// outputs (es_fwd_valid, es_fwd_dest, es_fwd_data, es_fwd_is_load).
// Modports:
//   master - the surrounding pipeline (drives ds_to_es_*, ms_allowin)
//   slave  - exe_stage
interface exe_stage_if
  import mycpu_pkg::*;
;
  logic                  ds_to_es_valid;
  logic                  es_allowin;
  logic [DS_TO_ES_W-1:0] ds_to_es_bus;
  logic                  ms_allowin;
  logic                  es_to_ms_valid;
  logic [ES_TO_MS_W-1:0] es_to_ms_bus;
  logic                  data_sram_en;
  logic [3:0]            data_sram_we;
  logic [31:0]           data_sram_addr;
  logic [31:0]           data_sram_wdata;
`ifdef EXE_FWD_EN
  logic                  es_fwd_valid;
  logic [4:0]            es_fwd_dest;
  logic [31:0]           es_fwd_data;
  logic                  es_fwd_is_load;
`endif

  modport master (
    output ds_to_es_valid, ds_to_es_bus, ms_allowin,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
`ifdef EXE_FWD_EN
    , input es_fwd_valid, es_fwd_dest, es_fwd_data, es_fwd_is_load
`endif
  );

  modport slave (
    input  ds_to_es_valid, ds_to_es_bus, ms_allowin,
    output es_allowin, es_to_ms_valid, es_to_ms_bus,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
`ifdef EXE_FWD_EN
    , output es_fwd_valid, es_fwd_dest, es_fwd_data, es_fwd_is_load
`endif
  );

endinterface

// File: rtl/alu.sv
// Shared combinational ALU.
// Ports:
//   alu_op     in  12  one-hot operation select (ALU_OP_* indices)
//   alu_src1   in  32  first operand
//   alu_src2   in  32  second operand (shift amount in [4:0]; lui passes it)
//   alu_result out 32  result
module alu
  import mycpu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         alu_src1,
  input  logic [31:0]         alu_src2,
  output logic [31:0]         alu_result
);

  logic        use_sub;
  logic [31:0] adder_b;
  logic [32:0] adder_out;
  logic [31:0] sum;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  // Subtraction and both compares share one adder: a + ~b + 1.
  assign use_sub   = alu_op[ALU_OP_SUB] | alu_op[ALU_OP_SLT] | alu_op[ALU_OP_SLTU];
  assign adder_b   = use_sub ? ~alu_src2 : alu_src2;
  assign adder_out = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};
  assign sum       = adder_out[31:0];

  // Signed less-than: differing signs decide directly, otherwise the sign of a-b.
  assign slt_res  = (alu_src1[31] & ~alu_src2[31])
                  | (~(alu_src1[31] ^ alu_src2[31]) & sum[31]);
  // Unsigned less-than: no carry out of a + ~b + 1 means a < b.
  assign sltu_res = ~adder_out[32];

  assign sll_res = alu_src1 << alu_src2[4:0];
  assign srl_res = alu_src1 >> alu_src2[4:0];
  assign sra_res = $signed(alu_src1) >>> alu_src2[4:0];

  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_OP_ADD] | alu_op[ALU_OP_SUB]) alu_result = alu_result | sum;
    if (alu_op[ALU_OP_SLT])  alu_result = alu_result | {31'd0, slt_res};
    if (alu_op[ALU_OP_SLTU]) alu_result = alu_result | {31'd0, sltu_res};
    if (alu_op[ALU_OP_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[ALU_OP_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[ALU_OP_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[ALU_OP_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[ALU_OP_SLL])  alu_result = alu_result | sll_res;
    if (alu_op[ALU_OP_SRL])  alu_result = alu_result | srl_res;
    if (alu_op[ALU_OP_SRA])  alu_result = alu_result | sra_res;
    if (alu_op[ALU_OP_LUI])  alu_result = alu_result | alu_src2;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the five-stage in-order pipeline (between ID and MEM).
// Holds the ID->EX pipeline register, takes part in the valid/allowin
// handshake on both sides, selects ALU operands, issues the single data-SRAM
// request for loads/stores and forwards the result bundle to MEM.
// Ports:
//   clk    in  pipeline clock
//   reset  in  synchronous active-high reset
//   es_if  exe_stage_if.slave: ds_to_es_valid/bus, es_allowin, ms_allowin,
//          es_to_ms_valid/bus, data_sram_en/we/addr/wdata
// Optional: define EXE_FWD_EN to drive es_fwd_valid/dest/data/is_load for
// ID bypass and load-use interlock.
module exe_stage
  import mycpu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  exe_stage_if.slave es_if
);

  logic                  es_valid;
  logic [DS_TO_ES_W-1:0] ds_to_es_bus_r;
  logic                  es_ready_go;

  logic [ALU_OP_W-1:0]   alu_op;
  logic [31:0]           es_pc;
  logic [31:0]           rj_value;
  logic [31:0]           rkd_value;
  logic [31:0]           imm;
  logic                  src1_is_pc;
  logic                  src2_is_imm;
  logic                  res_from_mem;
  logic                  mem_we;
  logic                  gr_we;
  logic [4:0]            dest;

  logic [31:0]           alu_src1;
  logic [31:0]           alu_src2;
  logic [31:0]           alu_result;

  assign es_ready_go       = 1'b1;
  assign es_if.es_allowin     = ~es_valid | (es_ready_go & es_if.ms_allowin);
  assign es_if.es_to_ms_valid = es_valid & es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid       <= 1'b0;
      ds_to_es_bus_r <= '0;
    end else if (es_if.es_allowin) begin
      es_valid <= es_if.ds_to_es_valid;
      if (es_if.ds_to_es_valid) begin
        ds_to_es_bus_r <= es_if.ds_to_es_bus;
      end
    end
  end

  assign alu_op       = ds_to_es_bus_r[DS_ALU_OP_MSB:DS_ALU_OP_LSB];
  assign es_pc        = ds_to_es_bus_r[DS_PC_MSB:DS_PC_LSB];
  assign rj_value     = ds_to_es_bus_r[DS_RJ_MSB:DS_RJ_LSB];
  assign rkd_value    = ds_to_es_bus_r[DS_RKD_MSB:DS_RKD_LSB];
  assign imm          = ds_to_es_bus_r[DS_IMM_MSB:DS_IMM_LSB];
  assign src1_is_pc   = ds_to_es_bus_r[DS_SRC1_IS_PC];
  assign src2_is_imm  = ds_to_es_bus_r[DS_SRC2_IS_IMM];
  assign res_from_mem = ds_to_es_bus_r[DS_RES_FROM_MEM];
  assign mem_we       = ds_to_es_bus_r[DS_MEM_WE];
  assign gr_we        = ds_to_es_bus_r[DS_GR_WE];
  assign dest         = ds_to_es_bus_r[DS_DEST_MSB:DS_DEST_LSB];

  assign alu_src1 = src1_is_pc  ? es_pc : rj_value;
  assign alu_src2 = src2_is_imm ? imm   : rkd_value;

  alu u_alu (
    .alu_op    (alu_op),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .alu_result(alu_result)
  );

  // Gating with ms_allowin makes the request one-shot: it fires only in the
  // cycle the instruction leaves EX, so a MEM stall cannot repeat a store.
  assign es_if.data_sram_en    = es_valid & (res_from_mem | mem_we) & es_if.ms_allowin;
  assign es_if.data_sram_we    = {4{es_valid & mem_we & es_if.ms_allowin}};
  assign es_if.data_sram_addr  = alu_result;
  assign es_if.data_sram_wdata = rkd_value;

  assign es_if.es_to_ms_bus = {es_pc, alu_result, res_from_mem, gr_we, dest};

`ifdef EXE_FWD_EN
  assign es_if.es_fwd_valid   = es_valid & gr_we & (dest != 5'd0);
  assign es_if.es_fwd_dest    = dest;
  assign es_if.es_fwd_data    = alu_result;
  assign es_if.es_fwd_is_load = res_from_mem;
`endif

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic clk;
  logic reset;

  exe_stage_if bus_if ();

  exe_stage u_dut (
    .clk  (clk),
    .reset(reset),
    .es_if(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  typedef struct {
    logic [11:0] op;
    logic [31:0] pc;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] imm;
    logic        s1pc;
    logic        s2imm;
    logic        rfm;
    logic        mwe;
    logic        gwe;
    logic [4:0]  dest;
    logic [31:0] exp_res;
  } vec_t;

  typedef struct {
    logic [70:0] bus;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fv;
    logic [4:0]  fdest;
    logic [31:0] fdata;
    logic        fload;
  } exp_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        sb[$];
  vec_t        vecs[16];

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] op, input logic [31:0] pc,
                              input logic [31:0] rj, input logic [31:0] rkd,
                              input logic [31:0] imm, input logic s1pc,
                              input logic s2imm, input logic rfm, input logic mwe,
                              input logic gwe, input logic [4:0] dest,
                              input logic [31:0] exp_res);
    vec_t v;
    v.op = op; v.pc = pc; v.rj = rj; v.rkd = rkd; v.imm = imm;
    v.s1pc = s1pc; v.s2imm = s2imm; v.rfm = rfm; v.mwe = mwe; v.gwe = gwe;
    v.dest = dest; v.exp_res = exp_res;
    return v;
  endfunction

  function automatic logic [149:0] pack_ds(input vec_t v);
    return {v.op, v.pc, v.rj, v.rkd, v.imm, v.s1pc, v.s2imm, v.rfm, v.mwe, v.gwe, v.dest};
  endfunction

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.bus   = {v.pc, v.exp_res, v.rfm, v.gwe, v.dest};
    e.en    = v.rfm | v.mwe;
    e.we    = v.mwe ? 4'hf : 4'h0;
    e.addr  = v.exp_res;
    e.wdata = v.rkd;
    e.fv    = v.gwe & (v.dest != 5'd0);
    e.fdest = v.dest;
    e.fdata = v.exp_res;
    e.fload = v.rfm;
    return e;
  endfunction

  task automatic drive(input vec_t v, input logic ms_ok);
    bus_if.ds_to_es_bus   = pack_ds(v);
    bus_if.ds_to_es_valid = 1'b1;
    bus_if.ms_allowin     = ms_ok;
  endtask

  // Scoreboard: each instruction leaving EX toward MEM is checked against
  // the oldest expected record.
  always @(negedge clk) begin
    if (!reset && bus_if.es_to_ms_valid && bus_if.ms_allowin) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 71'(bus_if.es_to_ms_bus), 71'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("es_to_ms_bus", bus_if.es_to_ms_bus, e.bus);
        chk("sram_en", 71'(bus_if.data_sram_en), 71'(e.en));
        chk("sram_we", 71'(bus_if.data_sram_we), 71'(e.we));
        if (e.en) begin
          chk("sram_addr", 71'(bus_if.data_sram_addr), 71'(e.addr));
          chk("sram_wdata", 71'(bus_if.data_sram_wdata), 71'(e.wdata));
        end
`ifdef EXE_FWD_EN
        chk("fwd_valid", 71'(bus_if.es_fwd_valid), 71'(e.fv));
        chk("fwd_dest", 71'(bus_if.es_fwd_dest), 71'(e.fdest));
        chk("fwd_data", 71'(bus_if.es_fwd_data), 71'(e.fdata));
        chk("fwd_is_load", 71'(bus_if.es_fwd_is_load), 71'(e.fload));
`endif
      end
    end
  end

  initial begin
    vec_t st_a;
    vec_t st_b;
    exp_t e;

    vecs[0]  = mk(OP_ADD,  32'h1c000000, 32'd5,        32'd7,        32'h0,        0, 0, 0, 0, 1, 5'd4, 32'd12);
    vecs[1]  = mk(OP_SUB,  32'h1c000004, 32'd3,        32'd5,        32'h0,        0, 0, 0, 0, 1, 5'd5, 32'hfffffffe);
    vecs[2]  = mk(OP_SLT,  32'h1c000008, 32'hffffffff, 32'd1,        32'h0,        0, 0, 0, 0, 1, 5'd7, 32'd1);
    vecs[3]  = mk(OP_SLTU, 32'h1c00000c, 32'hffffffff, 32'd1,        32'h0,        0, 0, 0, 0, 1, 5'd8, 32'd0);
    vecs[4]  = mk(OP_AND,  32'h1c000010, 32'hf0f0ff00, 32'h0ff00ff0, 32'h0,        0, 0, 0, 0, 1, 5'd9, 32'h00f00f00);
    vecs[5]  = mk(OP_NOR,  32'h1c000014, 32'hf0f00000, 32'h0f0f0000, 32'h0,        0, 0, 0, 0, 1, 5'd10, 32'h0000ffff);
    vecs[6]  = mk(OP_OR,   32'h1c000018, 32'h12000000, 32'h99999999, 32'h34,       0, 1, 0, 0, 1, 5'd11, 32'h12000034);
    vecs[7]  = mk(OP_XOR,  32'h1c00001c, 32'haaaa5555, 32'hffff0000, 32'h0,        0, 0, 0, 0, 1, 5'd12, 32'h55555555);
    vecs[8]  = mk(OP_SLL,  32'h1c000020, 32'd1,        32'h0,        32'd31,       0, 1, 0, 0, 1, 5'd13, 32'h80000000);
    vecs[9]  = mk(OP_SRL,  32'h1c000024, 32'h80000000, 32'd4,        32'h0,        0, 0, 0, 0, 1, 5'd14, 32'h08000000);
    vecs[10] = mk(OP_SRA,  32'h1c000028, 32'h80000000, 32'd4,        32'h0,        0, 0, 0, 0, 1, 5'd15, 32'hf8000000);
    vecs[11] = mk(OP_LUI,  32'h1c00002c, 32'h77777777, 32'h0,        32'h12345000, 0, 1, 0, 0, 1, 5'd16, 32'h12345000);
    vecs[12] = mk(OP_ADD,  32'h1c000010, 32'h5555aaaa, 32'h0,        32'h20,       1, 1, 0, 0, 1, 5'd17, 32'h1c000030);
    vecs[13] = mk(OP_ADD,  32'h1c000034, 32'h1000,     32'hdeadbeef, 32'h10,       0, 1, 0, 1, 0, 5'd0, 32'h1010);
    vecs[14] = mk(OP_ADD,  32'h1c000038, 32'h2000,     32'h0,        32'h4,        0, 1, 1, 0, 1, 5'd6, 32'h2004);
    vecs[15] = mk(OP_ADD,  32'h1c00003c, 32'd1,        32'd1,        32'h0,        0, 0, 0, 0, 1, 5'd0, 32'd2);

    st_a = mk(OP_ADD, 32'h1c000100, 32'h1000, 32'hdeadbeef, 32'h10, 0, 1, 0, 1, 0, 5'd0, 32'h1010);
    st_b = mk(OP_ADD, 32'h1c000200, 32'h3000, 32'hcafef00d, 32'h8,  0, 1, 0, 1, 0, 5'd0, 32'h3008);

    reset                 = 1'b1;
    bus_if.ds_to_es_valid = 1'b0;
    bus_if.ds_to_es_bus   = '0;
    bus_if.ms_allowin     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_allowin", 71'(bus_if.es_allowin), 71'(1));
    chk("rst_to_ms_valid", 71'(bus_if.es_to_ms_valid), 71'(0));
    chk("rst_sram_en", 71'(bus_if.data_sram_en), 71'(0));
    chk("rst_sram_we", 71'(bus_if.data_sram_we), 71'(0));

    // Back-to-back vectors with no MEM back-pressure
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        chk("b2b_to_ms_valid", 71'(bus_if.es_to_ms_valid), 71'(1));
        chk("b2b_allowin", 71'(bus_if.es_allowin), 71'(1));
      end
      drive(vecs[i], 1'b1);
      sb.push_back(mk_exp(vecs[i]));
      @(posedge clk);
      #1;
    end
    bus_if.ds_to_es_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_to_ms_valid", 71'(bus_if.es_to_ms_valid), 71'(0));
    chk("drain_sram_en", 71'(bus_if.data_sram_en), 71'(0));

    // Store held by a 3-cycle MEM stall, then released
    drive(st_a, 1'b0);
    sb.push_back(mk_exp(st_a));
    e = mk_exp(st_a);
    @(posedge clk);
    #1;
    bus_if.ds_to_es_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_allowin", 71'(bus_if.es_allowin), 71'(0));
      chk("stall_sram_we", 71'(bus_if.data_sram_we), 71'(0));
      chk("stall_sram_en", 71'(bus_if.data_sram_en), 71'(0));
      chk("stall_bus", bus_if.es_to_ms_bus, e.bus);
      @(posedge clk);
      #1;
    end
    bus_if.ms_allowin = 1'b1;
    #1;
    chk("release_sram_en", 71'(bus_if.data_sram_en), 71'(1));
    chk("release_sram_we", 71'(bus_if.data_sram_we), 71'(4'hf));
    chk("release_allowin", 71'(bus_if.es_allowin), 71'(1));
    @(posedge clk);
    #1;
    chk("post_release_valid", 71'(bus_if.es_to_ms_valid), 71'(0));
    chk("post_release_en", 71'(bus_if.data_sram_en), 71'(0));
    chk("post_release_we", 71'(bus_if.data_sram_we), 71'(0));

    // Reset while a stalled store is held: it must be dropped
    drive(st_b, 1'b0);
    @(posedge clk);
    #1;
    bus_if.ds_to_es_valid = 1'b0;
    chk("held_to_ms_valid", 71'(bus_if.es_to_ms_valid), 71'(1));
    reset = 1'b1;
    #1;
    chk("rstcyc_sram_en", 71'(bus_if.data_sram_en), 71'(0));
    chk("rstcyc_sram_we", 71'(bus_if.data_sram_we), 71'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_if.ms_allowin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("after_rst_valid", 71'(bus_if.es_to_ms_valid), 71'(0));
      chk("after_rst_en", 71'(bus_if.data_sram_en), 71'(0));
      chk("after_rst_we", 71'(bus_if.data_sram_we), 71'(0));
      chk("after_rst_allowin", 71'(bus_if.es_allowin), 71'(1));
      @(posedge clk);
      #1;
    end

    chk("scoreboard_empty", 71'(sb.size()), 71'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the five-stage in-order pipeline. It sits between decode (ID) and memory (MEM).
- Holds the ID→EX pipeline register and takes part in the valid/allowin handshake with both neighbours.
- Selects the ALU operands and instantiates the shared ALU.
- Issues the single data-SRAM request for loads and stores, then forwards the result bundle to MEM.

Parameters:
DS_TO_ES_W, 150, width of ID→EX bus (field layout fixed in package)
ES_TO_MS_W, 71, width of EX→MEM bus

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous active-high reset
ds_to_es_valid  in  1  ID holds a valid instruction for EX
es_allowin  out  1  EX can accept a new instruction this cycle
ds_to_es_bus  in  DS_TO_ES_W  {alu_op[11:0], pc[31:0], rj_value[31:0], rkd_value[31:0], imm[31:0], src1_is_pc, src2_is_imm, res_from_mem, mem_we, gr_we, dest[4:0]} (MSB→LSB)
ms_allowin  in  1  MEM can accept
es_to_ms_valid  out  1  EX instruction is valid and ready to move to MEM
es_to_ms_bus  out  ES_TO_MS_W  {pc[31:0], alu_result[31:0], res_from_mem, gr_we, dest[4:0]}
data_sram_en  out  1  data SRAM request enable
data_sram_we  out  4  byte write enables
data_sram_addr  out  32  byte address (= alu_result)
data_sram_wdata  out  32  store data (= rkd_value)

Behaviour:
- Registers: es_valid (1 bit) and ds_to_es_bus_r (DS_TO_ES_W bits).
- Reset (sync, active-high):
  - es_valid=0 and ds_to_es_bus_r=0.
  - Consequently es_to_ms_valid=0, data_sram_en=0, data_sram_we=0, and es_allowin=1 in the cycle after reset.
- es_ready_go=1. Every instruction spends exactly one cycle in EX when there is no back-pressure.
- es_allowin = ~es_valid | (es_ready_go & ms_allowin).
- es_to_ms_valid = es_valid & es_ready_go.
- At each posedge, when not in reset:
  - If es_allowin, es_valid <= ds_to_es_valid.
  - If ds_to_es_valid & es_allowin, ds_to_es_bus_r <= ds_to_es_bus.
  - Otherwise both registers hold.
- Stall: while ms_allowin=0, es_valid and the latched bus hold unchanged. es_to_ms_bus stays stable.
- ALU operand selection:
  - alu_src1 = src1_is_pc ? pc : rj_value.
  - alu_src2 = src2_is_imm ? imm : rkd_value.
  - alu_op is passed through unchanged. The ALU result is combinational from the latched bus.
- Memory request (one-shot):
  - data_sram_en = es_valid & (res_from_mem | mem_we) & ms_allowin.
  - data_sram_we = {4{es_valid & mem_we & ms_allowin}}.
  - The request is therefore asserted only in the cycle the instruction moves to MEM. A stall never produces a duplicate store.
- Word accesses only. Address bits [1:0] are passed through unchecked.
- es_to_ms_bus is packed from the latched pc, the alu_result, and the latched res_from_mem, gr_we and dest.
- An invalid EX slot (es_valid=0) must drive data_sram_en=0 and data_sram_we=0, whatever the stale bus contents.
- Simultaneous accept and issue: when EX drains to MEM in the same cycle ID presents an instruction, the new instruction is latched with no bubble.
- Reset asserted mid-stall: the instruction is discarded and no SRAM request is made in the reset cycle or after it.

Optional Feature:
- Macro EXE_FWD_EN.
- When defined, EX adds these outputs: es_fwd_valid (1), es_fwd_dest (5), es_fwd_data (32), es_fwd_is_load (1), used by ID for bypass and load-use interlock.
  - es_fwd_valid = es_valid & gr_we & (dest!=0).
  - es_fwd_data = alu_result.
  - es_fwd_is_load = res_from_mem.
- When undefined, these ports do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package mycpu_pkg holds:
  - DS_TO_ES_W and ES_TO_MS_W;
  - the field MSB/LSB constants for both buses;
  - the ALU_OP_* one-hot bit indices 0–11 (add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui).
- One sub-module: the existing alu, instantiated unmodified.
- No other hierarchy.

Test Plan:
- add.w: pc=0x1c000000, rj=5, rk=7, alu_op=ADD, gr_we=1, dest=4, ms_allowin=1 → next cycle es_to_ms_valid=1, alu_result=12, dest=4, data_sram_en=0.
- st.w: rj=0x1000, imm=0x10, rkd=0xdeadbeef, mem_we=1, src2_is_imm=1 → data_sram_en=1, we=4'hf, addr=0x1010, wdata=0xdeadbeef for exactly one cycle.
- Same st.w with ms_allowin=0 for 3 cycles, then 1 → es_allowin=0 and data_sram_we=0 during the stall; exactly one request with we=4'hf in the release cycle; bus stable throughout the stall.
- Back-to-back: ds_to_es_valid=1 for 4 cycles with ms_allowin=1 → 4 consecutive es_to_ms_valid cycles, no bubbles, results in order.
- reset=1 while a stalled st.w is held → es_valid=0 and no SRAM request in the next cycle or afterwards; es_allowin=1.
- EXE_FWD_EN: ld.w to dest=6 → es_fwd_valid=1, es_fwd_is_load=1; an instruction with dest=0 → es_fwd_valid=0.
